// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   - default data/address widths (match the regfile)
//   - REG_ZERO: address of the hard-wired zero register (writes dropped)
//   - SRC_A / SRC_B: bit positions of the two sources in req/gnt vectors
//   - pri_e: arbiter state, i.e. which source wins the next tie
//   - next_pri(): state update rule shared by the top-level FSM
package regfile_wr_arbiter_pkg;

    localparam int MEM_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 5;

    // Register 0 is architecturally zero; a write to it is accepted but dropped.
    localparam int REG_ZERO = 0;

    localparam int SRC_A = 0;
    localparam int SRC_B = 1;

    // PRI_A: last transfer went to B (or reset), so A wins a tie.
    // PRI_B: last transfer went to A, so B wins a tie.
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    // The preference only moves when something was actually granted; it
    // flips to the side that did not just win.
    function automatic pri_e next_pri(input logic [1:0] gnt, input pri_e cur);
        pri_e nxt;
        nxt = cur;
        if (gnt[SRC_A]) begin
            nxt = PRI_B;
        end else if (gnt[SRC_B]) begin
            nxt = PRI_A;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bus bundle between the two writeback sources, the arbiter and the regfile.
//
// Handshake: x_req/x_addr/x_data come from source x; x_gnt is the arbiter's
// combinational accept. A transfer happens at a posedge where x_req & x_gnt
// are both 1. A source keeps req/addr/data stable until granted, but may drop
// req without a grant (withdraw). stall=1 blocks all grants for that cycle.
//
// Write side: w_ena/w_addr/w_data drive the regfile write port (registered);
// fwd_* mirror them so readers can bypass the one-cycle write-visibility gap.
//
// Modports: master = sources + regfile side (drives requests, sees results),
//           slave  = the arbiter.
interface regfile_wr_arbiter_if
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [MEM_WIDTH-1:0]  a_data;
    logic                  a_gnt;

    logic                  b_req;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [MEM_WIDTH-1:0]  b_data;
    logic                  b_gnt;

    logic                  stall;

    logic                  w_ena;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [MEM_WIDTH-1:0]  w_data;

    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_addr;
    logic [MEM_WIDTH-1:0]  fwd_data;

    modport master (
        output a_req, a_addr, a_data,
        output b_req, b_addr, b_data,
        output stall,
        input  a_gnt, b_gnt,
        input  w_ena, w_addr, w_data,
        input  fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  a_req, a_addr, a_data,
        input  b_req, b_addr, b_data,
        input  stall,
        output a_gnt, b_gnt,
        output w_ena, w_addr, w_data,
        output fwd_valid, fwd_addr, fwd_data
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic (purely combinational).
//   req[1:0]  in   request vector, bit SRC_A / SRC_B
//   pri       in   current preference (which side wins a tie)
//   gnt[1:0]  out  one-hot or zero; never both bits set
// A lone request is always granted; with both requesting, the preferred side
// wins. Masking (stall, reset) is done by the caller on req.
module rr_arb2
    import regfile_wr_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  pri_e       pri,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (pri == PRI_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single regfile write port between source A
// (ALU result) and source B (load return) with round-robin arbitration and a
// single registered write stage.
//   clk       in   clock, all state updates on posedge
//   rst_n     in   synchronous active-low reset
//   bus       slave modport: a_*/b_* requests and grants, stall,
//             w_* regfile write port, fwd_* in-flight write for bypass
//   dbg_pri   out  current arbiter state (PRI_A = A wins next tie)
// Latency: granted in cycle N -> w_ena high in cycle N+1.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus,
    output pri_e                 dbg_pri
);

    // State and write stage
    pri_e                  pri_q,    pri_d;
    logic                  w_ena_q,  w_ena_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [MEM_WIDTH-1:0]  w_data_q, w_data_d;

    logic [1:0]            req_eff;
    logic [1:0]            gnt;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [MEM_WIDTH-1:0]  win_data;

    // Grants are suppressed both while stalled and while reset is asserted,
    // so nothing is accepted on the reset edge itself.
    always_comb begin
        req_eff = {bus.b_req, bus.a_req} & {2{rst_n & ~bus.stall}};
    end

    rr_arb2 u_rr_arb2 (
        .req (req_eff),
        .pri (pri_q),
        .gnt (gnt)
    );

    always_comb begin
        transfer = gnt[SRC_A] | gnt[SRC_B];
        win_addr = gnt[SRC_B] ? bus.b_addr : bus.a_addr;
        win_data = gnt[SRC_B] ? bus.b_data : bus.a_data;
    end

    always_comb begin
        pri_d    = next_pri(gnt, pri_q);
        w_ena_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (transfer) begin
            w_addr_d = win_addr;
            w_data_d = win_data;
            // r0 writes are granted (the source is released) but never reach
            // the regfile.
            w_ena_d  = (win_addr != ADDR_WIDTH'(REG_ZERO));
        end
    end

    // Single sequential block: FSM (pri) plus the registered write stage.
    // Reset cancels any write that was about to be presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pri_q    <= PRI_A;
            w_ena_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            pri_q    <= pri_d;
            w_ena_q  <= w_ena_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign bus.a_gnt     = gnt[SRC_A];
    assign bus.b_gnt     = gnt[SRC_B];
    assign bus.w_ena     = w_ena_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.fwd_valid = w_ena_q;
    assign bus.fwd_addr  = w_addr_q;
    assign bus.fwd_data  = w_data_q;
    assign dbg_pri       = pri_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios followed by random traffic.
// The driver computes expected grants from the arbitration rules and pushes
// every expected regfile write into exp_q; the monitor pops one entry each
// time the DUT raises w_ena.
module tb_regfile_wr_arbiter;
    import regfile_wr_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 16;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.MEM_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    pri_e dbg_pri;

    regfile_wr_arbiter #(.MEM_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dbg_pri (dbg_pri)
    );

    // Scoreboard
    logic [AW+DW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which side received the most recent transfer (1 = B).
    int last_src = 1;
    logic model_gnt_a, model_gnt_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Driver: apply one cycle of inputs at negedge, check grants against the
    // arbitration rules and predict the resulting write.
    task automatic drive_cycle(
        input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
        input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
        input logic st, input logic rn, input string tag);
        logic ea, eb;
        @(negedge clk);
        bus.a_req = ar; bus.a_addr = aa; bus.a_data = ad;
        bus.b_req = br; bus.b_addr = ba; bus.b_data = bd;
        bus.stall = st;
        rst_n     = rn;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (rn && !st) begin
            if (ar && br) begin
                if (last_src == 1) ea = 1'b1; else eb = 1'b1;
            end else if (ar) begin
                ea = 1'b1;
            end else if (br) begin
                eb = 1'b1;
            end
        end
        check({tag, "_gnt"}, {30'd0, bus.b_gnt, bus.a_gnt}, {30'd0, eb, ea});
        if (!rn) begin
            last_src = 1;
        end else if (ea) begin
            last_src = 0;
            if (aa != 0) exp_q.push_back({aa, ad});
        end else if (eb) begin
            last_src = 1;
            if (ba != 0) exp_q.push_back({ba, bd});
        end
        model_gnt_a = ea;
        model_gnt_b = eb;
    endtask

    task automatic idle_cycle(input string tag);
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, tag);
    endtask

    // Directly check the registered write stage (values written at last edge).
    task automatic check_w(input string tag, input logic e, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        check({tag, "_w_ena"},  {31'd0, bus.w_ena}, {31'd0, e});
        check({tag, "_w_addr"}, {27'd0, bus.w_addr}, {27'd0, a});
        check({tag, "_w_data"}, {16'd0, bus.w_data}, {16'd0, d});
    endtask

    // Monitor: after each edge, any w_ena must match the oldest expected write.
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.fwd_valid !== bus.w_ena || bus.fwd_addr !== bus.w_addr ||
                bus.fwd_data !== bus.w_data) begin
                n_err++;
                $display("FAIL fwd_mirror: got %b/%0h/%0h expected %b/%0h/%0h at %0t",
                         bus.fwd_valid, bus.fwd_addr, bus.fwd_data,
                         bus.w_ena, bus.w_addr, bus.w_data, $time);
            end
            if (bus.w_ena === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                             bus.w_addr, bus.w_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.w_addr, bus.w_data} !== e) begin
                        n_err++;
                        $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h at %0t",
                                 bus.w_addr, bus.w_data, e[AW+DW-1:DW], e[DW-1:0], $time);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic pa, pb, st, rn;
        logic [AW-1:0] paa, pba;
        logic [DW-1:0] pad, pbd;

        rst_n = 1'b0;
        bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.stall = 1'b0;

        // 1. Reset with both requesting: no grants, write stage cleared.
        drive_cycle(1'b1, 5'd5, 16'h1111, 1'b1, 5'd6, 16'h2222, 1'b0, 1'b0, "rst0");
        drive_cycle(1'b1, 5'd5, 16'h1111, 1'b1, 5'd6, 16'h2222, 1'b0, 1'b0, "rst1");
        check_w("rst", 1'b0, '0, '0);
        check("rst_pri", {31'd0, dbg_pri}, {31'd0, PRI_A});

        // 3. Contention right after reset: A first, then alternate.
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 5'd5, DW'(16'hA000 + i), 1'b1, 5'd6, DW'(16'hB000 + i),
                        1'b0, 1'b1, "cont");
        end

        // 2. Single A write.
        drive_cycle(1'b1, 5'd3, 16'h1234, 1'b0, '0, '0, 1'b0, 1'b1, "single_a");
        idle_cycle("single_a_next");
        check_w("single_a", 1'b1, 5'd3, 16'h1234);

        // 4. r0 write from B: granted, but w_ena stays low.
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 16'hFFFF, 1'b0, 1'b1, "r0");
        idle_cycle("r0_next");
        check_w("r0", 1'b0, 5'd0, 16'hFFFF);

        // 5. Stall with both requesting, then release: A preferred (last was B).
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 5'd9, 16'h0909, 1'b1, 5'd10, 16'h1010, 1'b1, 1'b1, "stall");
        end
        check_w("stall", 1'b0, 5'd0, 16'hFFFF);
        drive_cycle(1'b1, 5'd9, 16'h0909, 1'b1, 5'd10, 16'h1010, 1'b0, 1'b1, "unstall");
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd10, 16'h1010, 1'b0, 1'b1, "unstall_b");

        // 6. Reset right behind a transfer: the in-flight write is cleared.
        drive_cycle(1'b1, 5'd7, 16'hABCD, 1'b0, '0, '0, 1'b0, 1'b1, "mid_xfer");
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, "mid_rst");
        check_w("mid_inflight", 1'b1, 5'd7, 16'hABCD);
        idle_cycle("mid_after");
        check_w("mid_after", 1'b0, '0, '0);

        // Random traffic obeying hold-until-granted, with withdraws,
        // stalls and occasional resets.
        pa = 1'b0; pb = 1'b0;
        paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa) begin
                pa  = ($urandom_range(0, 9) < 6);
                paa = AW'($urandom_range(0, 31));
                pad = DW'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                pa = 1'b0;
            end
            if (!pb) begin
                pb  = ($urandom_range(0, 9) < 6);
                pba = AW'($urandom_range(0, 31));
                pbd = DW'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                pb = 1'b0;
            end
            st = ($urandom_range(0, 6) == 0);
            rn = ($urandom_range(0, 49) != 0);
            drive_cycle(pa, paa, pad, pb, pba, pbd, st, rn, "rand");
            if (model_gnt_a || !rn) pa = 1'b0;
            if (model_gnt_b || !rn) pb = 1'b0;
        end

        idle_cycle("drain0");
        idle_cycle("drain1");
        idle_cycle("drain2");
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
